conv_col_feeder: RTL and testbench

Upstream feeder for the 3x3 convolver. It loads a 3x3 kernel as three 24-bit column pushes, then accepts a raster pixel stream. Two line buffers hold the previous rows, so each accepted pixel produces one 3-pixel vertical column {row r-2, r-1, r} on o_dato0..2 with o_valid. A window-valid flag marks which pushes complete a full 3x3 image window.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_col_feeder_if.sv | 37 +++
 rtl/conv_line_buf.sv | 29 ++
 rtl/conv_col_feeder.sv | 244 ++++++++++++++++++++++++
 tb/tb_conv_col_feeder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolver column feeder: widths, FSM encoding,
// kernel byte lanes and the frame-configuration legality check.
package conv_pkg;

    localparam int BIT_LEN = 8;
    localparam int M_LEN   = 3;
    localparam int KCOL_W  = M_LEN * BIT_LEN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KLOAD  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feed_state_t;

    // Byte position of each output lane inside one 24-bit kernel column
    localparam int KB_D0 = 0;
    localparam int KB_D1 = 1;
    localparam int KB_D2 = 2;

    localparam logic [1:0] KCNT_LAST = 2'd2;

    // A frame needs at least a 3x3 window and must fit the line buffers
    function automatic logic cfg_legal(input int unsigned width,
                                       input int unsigned height,
                                       input int unsigned max_w);
        return (width >= 32'd3) && (width <= max_w) && (height >= 32'd3);
    endfunction

endpackage

// File: rtl/conv_col_feeder_if.sv
// Configuration, pixel-stream and push-bus signals of the column feeder.
// master = the feeder itself, slave = the host/convolver side.
interface conv_col_feeder_if #(
    parameter int BIT_LEN = 8,
    parameter int COL_W   = 10
);
    logic                   i_start;
    logic [COL_W-1:0]       i_width;
    logic [COL_W-1:0]       i_height;
    logic [9*BIT_LEN-1:0]   i_kernel;

    logic [BIT_LEN-1:0]     s_pixel;
    logic                   s_valid;
    logic                   s_ready;

    logic [BIT_LEN-1:0]     o_dato0;
    logic [BIT_LEN-1:0]     o_dato1;
    logic [BIT_LEN-1:0]     o_dato2;
    logic                   o_selecK_I;
    logic                   o_valid;
    logic                   o_win_ok;
    logic                   o_eol;
    logic                   o_frame_done;
    logic                   o_cfg_err;

    modport master (
        input  i_start, i_width, i_height, i_kernel, s_pixel, s_valid,
        output s_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_win_ok, o_eol, o_frame_done, o_cfg_err
    );

    modport slave (
        output i_start, i_width, i_height, i_kernel, s_pixel, s_valid,
        input  s_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_win_ok, o_eol, o_frame_done, o_cfg_err
    );
endinterface

// File: rtl/conv_line_buf.sv
// One image line of storage: simple dual-port RAM, synchronous write,
// registered read that returns the old word when read and write collide.
module conv_line_buf #(
    parameter int BIT_LEN = 8,
    parameter int DEPTH   = 640,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [BIT_LEN-1:0] rd_data,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [BIT_LEN-1:0] wr_data
);
    logic [BIT_LEN-1:0] mem [DEPTH];
    logic [BIT_LEN-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/conv_col_feeder.sv
// Column feeder for the 3x3 convolver: three kernel column pushes, then one
// {r-2, r-1, r} pixel column per accepted pixel. Optional CONV_FEED_ZERO_INIT_EN
// zeroes the line-buffer lanes that have no valid history (rows 0 and 1).
module conv_col_feeder #(
    parameter int BIT_LEN = 8,
    parameter int MAX_W   = 640,
    parameter int COL_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    conv_col_feeder_if.master bus
);
    import conv_pkg::*;

    localparam int KW = M_LEN * BIT_LEN;

    feed_state_t          state_reg, state_next;
    logic [1:0]           kcnt_reg, kcnt_next;
    logic [COL_W-1:0]     width_reg, width_next;
    logic [COL_W-1:0]     height_reg, height_next;
    logic [9*BIT_LEN-1:0] kernel_reg, kernel_next;
    logic [COL_W-1:0]     col_reg, col_next;
    logic [COL_W-1:0]     row_reg, row_next;
    logic [KW-1:0]        kdat_reg, kdat_next;
    logic [BIT_LEN-1:0]   pix_reg, pix_next;
    logic                 sel_reg, sel_next;
    logic                 valid_reg, valid_next;
    logic                 win_reg, win_next;
    logic                 eol_reg, eol_next;
    logic                 cfg_err_reg, cfg_err_next;
    logic                 done_reg;

    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic                 cfg_ok;

    logic [KW-1:0]        kcol [M_LEN];
    logic [BIT_LEN-1:0]   img_lane [M_LEN];
    logic [BIT_LEN-1:0]   dato [M_LEN];

    logic [BIT_LEN-1:0]   lba_rd, lbb_rd;
    logic                 lba_wr_en_reg;
    logic [COL_W-1:0]     lba_wr_addr_reg;

    genvar gi;

    assign accept   = (state_reg == STREAM) && bus.s_valid;
    assign last_col = (col_reg == width_reg - 1'b1);
    assign last_row = (row_reg == height_reg - 1'b1);
    assign cfg_ok   = cfg_legal(32'(bus.i_width), 32'(bus.i_height), MAX_W);

    generate
        for (gi = 0; gi < M_LEN; gi++) begin : g_kcol
            assign kcol[gi] = kernel_reg[gi*KW +: KW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            kcnt_reg    <= '0;
            width_reg   <= '0;
            height_reg  <= '0;
            kernel_reg  <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            kdat_reg    <= '0;
            pix_reg     <= '0;
            sel_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            win_reg     <= 1'b0;
            eol_reg     <= 1'b0;
            cfg_err_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            kcnt_reg    <= kcnt_next;
            width_reg   <= width_next;
            height_reg  <= height_next;
            kernel_reg  <= kernel_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            kdat_reg    <= kdat_next;
            pix_reg     <= pix_next;
            sel_reg     <= sel_next;
            valid_reg   <= valid_next;
            win_reg     <= win_next;
            eol_reg     <= eol_next;
            cfg_err_reg <= cfg_err_next;
            // Pulse lands one cycle after the final push, i.e. after DONE
            done_reg    <= (state_reg == DONE);
        end
    end

    always_comb begin
        state_next   = state_reg;
        kcnt_next    = kcnt_reg;
        width_next   = width_reg;
        height_next  = height_reg;
        kernel_next  = kernel_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        kdat_next    = kdat_reg;
        pix_next     = pix_reg;
        sel_next     = sel_reg;
        valid_next   = 1'b0;
        win_next     = 1'b0;
        eol_next     = 1'b0;
        cfg_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    if (cfg_ok) begin
                        width_next  = bus.i_width;
                        height_next = bus.i_height;
                        kernel_next = bus.i_kernel;
                        kcnt_next   = '0;
                        col_next    = '0;
                        row_next    = '0;
                        state_next  = KLOAD;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            KLOAD: begin
                kdat_next  = kcol[kcnt_reg];
                sel_next   = 1'b0;
                valid_next = 1'b1;
                kcnt_next  = kcnt_reg + 1'b1;
                if (kcnt_reg == KCNT_LAST) begin
                    kcnt_next  = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    pix_next   = bus.s_pixel;
                    sel_next   = 1'b1;
                    valid_next = 1'b1;
                    win_next   = (row_reg >= COL_W'(2)) && (col_reg >= COL_W'(2));
                    eol_next   = last_col;
                    if (last_col) begin
                        col_next = '0;
                        row_next = row_reg + 1'b1;
                        if (last_row) begin
                            state_next = DONE;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // lbA takes lbB's old word, which is only available from lbB's registered
    // read one cycle later; the same column is never revisited that soon (width>=3).
    always_ff @(posedge clk) begin
        if (rst) begin
            lba_wr_en_reg <= 1'b0;
        end else begin
            lba_wr_en_reg <= accept;
        end
        lba_wr_addr_reg <= col_reg;
    end

    conv_line_buf #(
        .BIT_LEN (BIT_LEN),
        .DEPTH   (MAX_W),
        .ADDR_W  (COL_W)
    ) u_lba (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (col_reg),
        .rd_data (lba_rd),
        .wr_en   (lba_wr_en_reg),
        .wr_addr (lba_wr_addr_reg),
        .wr_data (lbb_rd)
    );

    conv_line_buf #(
        .BIT_LEN (BIT_LEN),
        .DEPTH   (MAX_W),
        .ADDR_W  (COL_W)
    ) u_lbb (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (col_reg),
        .rd_data (lbb_rd),
        .wr_en   (accept),
        .wr_addr (col_reg),
        .wr_data (bus.s_pixel)
    );

`ifdef CONV_FEED_ZERO_INIT_EN
    logic zero_d0_reg;
    logic zero_d1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_d0_reg <= 1'b0;
            zero_d1_reg <= 1'b0;
        end else if (accept) begin
            zero_d0_reg <= (row_reg < COL_W'(2));
            zero_d1_reg <= (row_reg == '0);
        end
    end

    assign img_lane[KB_D0] = zero_d0_reg ? '0 : lba_rd;
    assign img_lane[KB_D1] = zero_d1_reg ? '0 : lbb_rd;
`else
    assign img_lane[KB_D0] = lba_rd;
    assign img_lane[KB_D1] = lbb_rd;
`endif
    assign img_lane[KB_D2] = pix_reg;

    // Read registers and pix_reg only move on acceptance, so data holds in gaps
    generate
        for (gi = 0; gi < M_LEN; gi++) begin : g_lane
            assign dato[gi] = sel_reg ? img_lane[gi] : kdat_reg[gi*BIT_LEN +: BIT_LEN];
        end
    endgenerate

    assign bus.o_dato0      = dato[KB_D0];
    assign bus.o_dato1      = dato[KB_D1];
    assign bus.o_dato2      = dato[KB_D2];
    assign bus.o_selecK_I   = sel_reg;
    assign bus.o_valid      = valid_reg;
    assign bus.o_win_ok     = win_reg;
    assign bus.o_eol        = eol_reg;
    assign bus.o_frame_done = done_reg;
    assign bus.o_cfg_err    = cfg_err_reg;
    assign bus.s_ready      = (state_reg == STREAM);

endmodule

// File: tb/tb_conv_col_feeder.sv
// Scoreboard bench for conv_col_feeder: expected pushes come from a per-column
// pixel history model; a negedge monitor pops and compares every DUT event.
`timescale 1ns/1ps
module tb_conv_col_feeder;
    localparam int BL = 8;
    localparam int MW = 16;
    localparam int CW = 10;

    localparam int K_PUSH = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] d0, d1, d2;
        bit         k0, k1, sel, win, eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_col_feeder_if #(.BIT_LEN(BL), .COL_W(CW)) bus ();

    conv_col_feeder #(.BIT_LEN(BL), .MAX_W(MW), .COL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       q[$];
    logic [7:0] colhist[MW][$];
    int         checks = 0;
    int         errors = 0;
    exp_t       me;
    exp_t       last_e;
    bit         last_img = 0;
    int         since_push = 0;
    bit         acc_q = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit pop_item(input int kind, output exp_t e);
        e = '{default: 0};
        if (q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'hFF);
            return 0;
        end
        e = q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        return (e.kind == kind);
    endfunction

    // Column history: the two most recent pixels seen at each column index
    task automatic expect_pixel(input int r, input int c, input int w, input logic [7:0] p);
        exp_t e;
        int   n;
        e = '{default: 0};
        n = colhist[c].size();
        e.kind = K_PUSH;
        e.sel  = 1;
        e.d2   = p;
        e.k1   = (n >= 1);
        if (n >= 1) e.d1 = colhist[c][n-1];
        e.k0   = (n >= 2);
        if (n >= 2) e.d0 = colhist[c][n-2];
`ifdef CONV_FEED_ZERO_INIT_EN
        if (r == 0) begin e.k0 = 1; e.d0 = 8'h00; e.k1 = 1; e.d1 = 8'h00; end
        if (r == 1) begin e.k0 = 1; e.d0 = 8'h00; end
`endif
        e.win = (r >= 2) && (c >= 2);
        e.eol = (c == w - 1);
        q.push_back(e);
        colhist[c].push_back(p);
        if (colhist[c].size() > 2) void'(colhist[c].pop_front());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.o_valid, 0);
        chk({tag, "_ready"}, bus.s_ready, 0);
        chk({tag, "_dato"}, {bus.o_dato2, bus.o_dato1, bus.o_dato0}, 0);
        chk({tag, "_flags"}, {bus.o_selecK_I, bus.o_win_ok, bus.o_eol, bus.o_frame_done, bus.o_cfg_err}, 0);
    endtask

    task automatic bad_cfg(input int w, input int h);
        exp_t e;
        e = '{default: 0};
        e.kind = K_ERR;
        q.push_back(e);
        bus.i_width  = CW'(w);
        bus.i_height = CW'(h);
        bus.i_start  = 1'b1;
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("cfg_err_stays_idle_ready", bus.s_ready, 0);
    endtask

    // mode 0: s_valid always 1, pixel 16*row+col; mode 1: same pixels with
    // 1/0 toggling; mode 2: random pixels and random gaps. abort_after>=0 stops early.
    task automatic run_frame(input int w, input int h, input logic [71:0] kern,
                             input int mode, input int abort_after);
        exp_t       e;
        logic [7:0] p;
        int         waitc;
        int         n;
        int         g;
        n = 0;
        for (int j = 0; j < 3; j++) begin
            e = '{default: 0};
            e.kind = K_PUSH;
            e.k0 = 1; e.k1 = 1; e.sel = 0;
            e.d0 = kern[24*j +: 8];
            e.d1 = kern[24*j + 8 +: 8];
            e.d2 = kern[24*j + 16 +: 8];
            q.push_back(e);
        end
        bus.i_width  = CW'(w);
        bus.i_height = CW'(h);
        bus.i_kernel = kern;
        bus.i_start  = 1'b1;
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (abort_after >= 0 && n == abort_after) begin
                    bus.s_valid = 1'b0;
                    return;
                end
                g = (mode == 1 && n > 0) ? 1 : (mode == 2 ? int'($urandom_range(0, 2)) : 0);
                if (g > 0) begin
                    bus.s_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
                p = (mode == 2) ? 8'($urandom) : 8'(16 * r + c);
                bus.s_pixel = p;
                bus.s_valid = 1'b1;
                waitc = 0;
                while (!bus.s_ready && waitc < 20) begin
                    @(posedge clk); #1;
                    waitc++;
                end
                if (!bus.s_ready) begin
                    chk("s_ready_timeout", bus.s_ready, 1);
                    bus.s_valid = 1'b0;
                    return;
                end
                expect_pixel(r, c, w, p);
                @(posedge clk); #1;
                n++;
            end
        end
        bus.s_valid = 1'b0;
        chk("s_ready_after_last", bus.s_ready, 0);
        e = '{default: 0};
        e.kind = K_DONE;
        q.push_back(e);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) acc_q <= !rst && bus.s_valid && bus.s_ready;

    always @(negedge clk) begin
        if (rst) begin
            last_img = 0;
        end else begin
            since_push++;
            chk("valid_latency", bus.o_valid & bus.o_selecK_I, acc_q);
            if (bus.o_frame_done) begin
                last_img = 0;
                chk("done_timing", 64'(since_push), 1);
                void'(pop_item(K_DONE, me));
            end
            if (bus.o_cfg_err) begin
                void'(pop_item(K_ERR, me));
            end
            if (bus.o_valid) begin
                since_push = 0;
                if (pop_item(K_PUSH, me)) begin
                    chk("push_sel", bus.o_selecK_I, me.sel);
                    chk("push_d2", bus.o_dato2, me.d2);
                    if (me.k1) chk("push_d1", bus.o_dato1, me.d1);
                    if (me.k0) chk("push_d0", bus.o_dato0, me.d0);
                    if (me.sel) begin
                        chk("push_win_ok", bus.o_win_ok, me.win);
                        chk("push_eol", bus.o_eol, me.eol);
                    end
                    last_e   = me;
                    last_img = me.sel;
                end
            end else if (last_img) begin
                chk("hold_d2", bus.o_dato2, last_e.d2);
                if (last_e.k1) chk("hold_d1", bus.o_dato1, last_e.d1);
                if (last_e.k0) chk("hold_d0", bus.o_dato0, last_e.d0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] kv;
        int          w, h;
        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_width  = '0;
        bus.i_height = '0;
        bus.i_kernel = '0;
        bus.s_pixel  = '0;
        bus.s_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("idle");

        bad_cfg(2, 4);
        $display("txn cfg width=2 rejected");
        bad_cfg(MW + 1, 4);
        $display("txn cfg width=%0d rejected", MW + 1);
        bad_cfg(4, 2);
        $display("txn cfg height=2 rejected");

        run_frame(4, 4, 72'h00_20_00_20_80_20_00_20_00, 0, -1);
        $display("txn frame 4x4 streaming");
        kv = 72'({$urandom, $urandom, $urandom});
        run_frame(4, 4, kv, 1, -1);
        $display("txn frame 4x4 toggling valid");
        for (int i = 0; i < 4; i++) begin
            w  = $urandom_range(3, 8);
            h  = $urandom_range(3, 5);
            kv = 72'({$urandom, $urandom, $urandom});
            run_frame(w, h, kv, 2, -1);
            $display("txn frame %0dx%0d random", w, h);
        end
        kv = 72'({$urandom, $urandom, $urandom});
        run_frame(MW, 3, kv, 2, -1);
        $display("txn frame %0dx3 max width", MW);

        kv = 72'({$urandom, $urandom, $urandom});
        run_frame(4, 4, kv, 0, 6);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn frame aborted after 6 pixels");
        kv = 72'({$urandom, $urandom, $urandom});
        run_frame(3, 3, kv, 2, -1);
        $display("txn frame 3x3 after abort");

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
